// File: rtl/y86_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : y86_pkg                                            |
// | Description : Shared Y86-64 definitions: register-index type,    |
// |               null/stack-pointer register indices, icode enum.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package y86_pkg;

  // Register index as used by the decode and write-back stages
  typedef logic [3:0] reg_idx_t;

  // "No register" index; any index at or above the register count is also null
  localparam reg_idx_t RNONE = 4'hF;
  // Stack pointer; popq %rsp writes it from both write-back ports
  localparam reg_idx_t RSP   = 4'h4;

  // Instruction codes of the Y86-64 ISA
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_scoreboard                                 |
// | Description : Per-register pending-write counters. Decode claims |
// |               destinations, write-back retires them; raises      |
// |               stall on operand hazard or counter overflow.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module regfile_scoreboard
  import y86_pkg::*;
#(
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   srcA_i,
  input  logic [ADDR_W-1:0]   srcB_i,
  input  logic [ADDR_W-1:0]   wr_dstE_i,
  input  logic [ADDR_W-1:0]   wr_dstM_i,
  input  logic                claim_valid_i,
  input  logic [ADDR_W-1:0]   claim_dstE_i,
  input  logic [ADDR_W-1:0]   claim_dstM_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] sb_busy_o
);

  // Two guard bits: pending + inc (up to 2) never wraps before the compare
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX_CNT = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] pending_q [NUM_REGS];
  logic [CNT_W-1:0] pending_d [NUM_REGS];
  logic [1:0]       inc_raw   [NUM_REGS];
  logic [1:0]       dec       [NUM_REGS];
  logic [1:0]       inc;
  logic [SW-1:0]    thr;
  logic [SW-1:0]    sum;
  logic             hz_a;
  logic             hz_b;
  logic             ovf;
  logic             stall;

  // Evaluate hazards/overflow, then apply qualified claims and retirements.
  // Null indices never match any r < NUM_REGS, so they are ignored for free.
  always_comb begin
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    ovf   = 1'b0;
    thr   = '0;
    inc   = '0;
    sum   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_raw[r] = {1'b0, claim_dstE_i == ADDR_W'(r)} + {1'b0, claim_dstM_i == ADDR_W'(r)};
      dec[r]     = {1'b0, wr_dstE_i == ADDR_W'(r)} + {1'b0, wr_dstM_i == ADDR_W'(r)};
      // Only one in-flight write can be forwarded; any more must still stall
      thr = (BYPASS != 0) ? SW'(dec[r]) : '0;
      if (SW'(pending_q[r]) + SW'(inc_raw[r]) > MAX_CNT) ovf = 1'b1;
      if ((srcA_i == ADDR_W'(r)) && (SW'(pending_q[r]) > thr)) hz_a = 1'b1;
      if ((srcB_i == ADDR_W'(r)) && (SW'(pending_q[r]) > thr)) hz_b = 1'b1;
    end
    stall = claim_valid_i && (hz_a || hz_b || ovf);
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = (claim_valid_i && !stall) ? inc_raw[r] : 2'd0;
      sum = SW'(pending_q[r]) + SW'(inc);
      // Retiring more than is pending is an illegal sequence; clamp at zero
      pending_d[r] = (sum < SW'(dec[r])) ? '0 : CNT_W'(sum - SW'(dec[r]));
    end
  end

  // Pending counters; reset drops all outstanding claims
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) pending_q[r] <= '0;
      else     pending_q[r] <= pending_d[r];
    end
  end

  // Busy flags straight from the counters
  always_comb begin
    sb_busy_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_busy_o[r] = (pending_q[r] != '0);
    end
  end

  assign stall_o = stall;

endmodule
`default_nettype wire

// File: rtl/y86_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : y86_regfile_sb                                     |
// | Description : Y86-64 register file with two read ports, E/M      |
// |               write-back ports, optional write-to-read bypass    |
// |               and a pending-write scoreboard.                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module y86_regfile_sb
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          srcA_i,
  input  logic [ADDR_W-1:0]          srcB_i,
  output logic [DATA_W-1:0]          valA_o,
  output logic [DATA_W-1:0]          valB_o,
  input  logic [ADDR_W-1:0]          wr_dstE_i,
  input  logic [DATA_W-1:0]          wr_valE_i,
  input  logic [ADDR_W-1:0]          wr_dstM_i,
  input  logic [DATA_W-1:0]          wr_valM_i,
  input  logic                       claim_valid_i,
  input  logic [ADDR_W-1:0]          claim_dstE_i,
  input  logic [ADDR_W-1:0]          claim_dstM_i,
  output logic                       stall_o,
  output logic [NUM_REGS-1:0]        sb_busy_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next register contents: E first, then M, so M wins on a shared index
  // (popq %rsp). Null indices match no entry and are dropped.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_dstE_i == ADDR_W'(r)) regs_d[r] = wr_valE_i;
      if (wr_dstM_i == ADDR_W'(r)) regs_d[r] = wr_valM_i;
    end
  end

  // Register storage
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) regs_q[r] <= '0;
      else     regs_q[r] <= regs_d[r];
    end
  end

  // Read muxes; regs_d already is the forwarded view with M over E priority
  always_comb begin
    valA_o = '0;
    valB_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (srcA_i == ADDR_W'(r)) valA_o = (BYPASS != 0) ? regs_d[r] : regs_q[r];
      if (srcB_i == ADDR_W'(r)) valB_o = (BYPASS != 0) ? regs_d[r] : regs_q[r];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .srcA_i        (srcA_i),
    .srcB_i        (srcB_i),
    .wr_dstE_i     (wr_dstE_i),
    .wr_dstM_i     (wr_dstM_i),
    .claim_valid_i (claim_valid_i),
    .claim_dstE_i  (claim_dstE_i),
    .claim_dstM_i  (claim_dstM_i),
    .stall_o       (stall_o),
    .sb_busy_o     (sb_busy_o)
  );

endmodule
`default_nettype wire
